psk_modulator: RTL and testbench

- Parametrised successor to the single-rate BPSK modulator: maps incoming symbols to signed I/Q baseband samples for the AT86RF215 IQ interface.
- Supports BPSK and Gray-coded QPSK, optional differential encoding, a valid/ready input handshake and a runtime symbol period.
- Sits between the CCSDS framing/coding chain and the IQ serialiser.
- Each output symbol is held for cycles_per_sym_i clocks; an underrun is flagged explicitly rather than silently zeroed.

---
 rtl/psk_pkg.sv | 33 +++
 rtl/psk_modulator_if.sv | 28 ++
 rtl/psk_mapper.sv | 51 +++++
 rtl/psk_modulator.sv | 95 +++++++++
 tb/tb_psk_modulator.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/psk_pkg.sv
// Shared types and helpers for the PSK modulator: mode/state encodings,
// quadrant sign lookup and the Gray-to-binary dibit conversion.
package psk_pkg;

   typedef enum logic {
      MODE_BPSK = 1'b0,
      MODE_QPSK = 1'b1
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   // Quadrant index -> {I negative, Q negative}:
   // 0 (+,+), 1 (-,+), 2 (-,-), 3 (+,-)
   function automatic logic [1:0] quad_sign(input logic [1:0] k);
      logic [1:0] s;
      case (k)
         2'd0:    s = 2'b00;
         2'd1:    s = 2'b10;
         2'd2:    s = 2'b11;
         default: s = 2'b01;
      endcase
      return s;
   endfunction

   // Gray-coded dibit to quadrant step: {d1, d1^d0}
   function automatic logic [1:0] gray2bin(input logic [1:0] d);
      return {d[1], d[1] ^ d[0]};
   endfunction

endpackage

// File: rtl/psk_modulator_if.sv
// Symbol input handshake and I/Q output bundle of the PSK modulator.
interface psk_modulator_if #(
   parameter int IQ_WIDTH  = 13,
   parameter int CNT_WIDTH = 32
);
   logic                        mode_i;
   logic                        diff_en_i;
   logic [CNT_WIDTH-1:0]        cycles_per_sym_i;
   logic [1:0]                  data_i;
   logic                        valid_i;
   logic                        ready_o;
   logic signed [IQ_WIDTH-1:0]  i_data_o;
   logic signed [IQ_WIDTH-1:0]  q_data_o;
   logic                        valid_o;
   logic                        underrun_o;

   // Upstream side: drives symbols, observes I/Q
   modport master (
      output mode_i, diff_en_i, cycles_per_sym_i, data_i, valid_i,
      input  ready_o, i_data_o, q_data_o, valid_o, underrun_o
   );

   // Modulator side
   modport slave (
      input  mode_i, diff_en_i, cycles_per_sym_i, data_i, valid_i,
      output ready_o, i_data_o, q_data_o, valid_o, underrun_o
   );
endinterface

// File: rtl/psk_mapper.sv
// Combinational symbol mapper: BPSK/QPSK, optional differential encoding.
// Produces the I/Q sample and the next differential state.
module psk_mapper
   import psk_pkg::*;
#(
   parameter int IQ_WIDTH = 13,
   parameter int AMP_BPSK = 4095,
   parameter int AMP_QPSK = 2896
) (
   input  logic                       i_mode,
   input  logic                       i_diff_en,
   input  logic [1:0]                 i_data,
   input  logic [1:0]                 i_k,
   output logic signed [IQ_WIDTH-1:0] o_i,
   output logic signed [IQ_WIDTH-1:0] o_q,
   output logic [1:0]                 o_k_next
);

   localparam logic signed [IQ_WIDTH-1:0] AMP_B = IQ_WIDTH'(AMP_BPSK);
   localparam logic signed [IQ_WIDTH-1:0] AMP_Q = IQ_WIDTH'(AMP_QPSK);

   logic       w_e;
   logic [1:0] w_quad;
   logic [1:0] w_sign;

   // Map symbol to quadrant, then quadrant to signed rail values
   always_comb begin
      w_e      = 1'b0;
      w_quad   = 2'd0;
      w_sign   = 2'b00;
      o_i      = '0;
      o_q      = '0;
      o_k_next = 2'd0;
      if (i_mode == MODE_BPSK) begin
         // Differential BPSK keeps the encoded bit itself in k[0]
         w_e      = i_diff_en ? (i_data[0] ^ i_k[0]) : i_data[0];
         w_quad   = w_e ? 2'd0 : 2'd2;
         w_sign   = quad_sign(w_quad);
         o_i      = w_sign[1] ? -AMP_B : AMP_B;
         o_q      = '0;
         o_k_next = i_diff_en ? {1'b0, w_e} : w_quad;
      end else begin
         w_quad   = i_diff_en ? (i_k + gray2bin(i_data)) : gray2bin(i_data);
         w_sign   = quad_sign(w_quad);
         o_i      = w_sign[1] ? -AMP_Q : AMP_Q;
         o_q      = w_sign[0] ? -AMP_Q : AMP_Q;
         o_k_next = w_quad;
      end
   end

endmodule

// File: rtl/psk_modulator.sv
// PSK modulator top: symbol handshake, per-symbol hold counter, underrun
// flagging and registered I/Q outputs.
module psk_modulator
   import psk_pkg::*;
#(
   parameter int IQ_WIDTH  = 13,
   parameter int AMP_BPSK  = 4095,
   parameter int AMP_QPSK  = 2896,
   parameter int CNT_WIDTH = 32
) (
   input  logic           clk_i,
   input  logic           rst_i,
   psk_modulator_if.slave bus
);

   state_e                      r_state;
   logic [CNT_WIDTH-1:0]        r_cnt;
   logic [CNT_WIDTH-1:0]        r_last;
   logic [1:0]                  r_k;
   logic signed [IQ_WIDTH-1:0]  r_i;
   logic signed [IQ_WIDTH-1:0]  r_q;
   logic                        r_valid;
   logic                        r_underrun;

   logic                        w_end;
   logic                        w_ready;
   logic                        w_accept;
   logic signed [IQ_WIDTH-1:0]  w_i;
   logic signed [IQ_WIDTH-1:0]  w_q;
   logic [1:0]                  w_k_next;

   psk_mapper #(
      .IQ_WIDTH (IQ_WIDTH),
      .AMP_BPSK (AMP_BPSK),
      .AMP_QPSK (AMP_QPSK)
   ) u_mapper (
      .i_mode    (bus.mode_i),
      .i_diff_en (bus.diff_en_i),
      .i_data    (bus.data_i),
      .i_k       (r_k),
      .o_i       (w_i),
      .o_q       (w_q),
      .o_k_next  (w_k_next)
   );

   // Ready in IDLE or on the last cycle of a held symbol
   always_comb begin
      w_end    = (r_state == HOLD) && (r_cnt == r_last);
      w_ready  = (r_state == IDLE) || w_end;
      w_accept = w_ready && bus.valid_i;
   end

   // Symbol FSM: accept, hold for the latched period, flag underrun on starve
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_last     <= '0;
         r_k        <= 2'd0;
         r_i        <= '0;
         r_q        <= '0;
         r_valid    <= 1'b0;
         r_underrun <= 1'b0;
      end else if (w_accept) begin
         r_state    <= HOLD;
         r_cnt      <= '0;
         r_last     <= (bus.cycles_per_sym_i == '0) ? '0
                       : bus.cycles_per_sym_i - CNT_WIDTH'(1);
         r_k        <= w_k_next;
         r_i        <= w_i;
         r_q        <= w_q;
         r_valid    <= 1'b1;
         r_underrun <= 1'b0;
      end else if (w_end) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_i        <= '0;
         r_q        <= '0;
         r_valid    <= 1'b0;
         r_underrun <= 1'b1;
      end else begin
         if (r_state == HOLD) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
         end
         r_underrun <= 1'b0;
      end
   end

   assign bus.ready_o    = w_ready;
   assign bus.i_data_o   = r_i;
   assign bus.q_data_o   = r_q;
   assign bus.valid_o    = r_valid;
   assign bus.underrun_o = r_underrun;

endmodule

// File: tb/tb_psk_modulator.sv
// Scoreboard bench for psk_modulator: driver pushes expected per-cycle
// samples from a phase-based reference model, monitor pops and compares.
module tb_psk_modulator;

   localparam int IQW = 13;
   localparam int CW  = 32;
   localparam int AB  = 4095;
   localparam int AQ  = 2896;

   typedef struct packed {
      logic signed [IQW-1:0] i;
      logic signed [IQW-1:0] q;
      logic                  v;
      logic                  u;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   psk_modulator_if #(.IQ_WIDTH(IQW), .CNT_WIDTH(CW)) bus ();

   psk_modulator #(
      .IQ_WIDTH  (IQW),
      .AMP_BPSK  (AB),
      .AMP_QPSK  (AQ),
      .CNT_WIDTH (CW)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   exp_t sb[$];
   int   vectors = 0;
   int   errors  = 0;
   int   m_k     = 0;   // model phase/differential state

   // Gray dibit -> quadrant, quadrant -> signs (I,Q), as constellation tables
   int gray_q [4] = '{0, 1, 3, 2};     // index by dibit {d1,d0}
   int sgn_i  [4] = '{1, -1, -1, 1};
   int sgn_q  [4] = '{1, 1, -1, -1};

   task automatic check(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: returns the expected sample for one accepted symbol
   task automatic model(input bit mode, input bit diff, input logic [1:0] d,
                        output int ei, output int eq);
      int e;
      if (!mode) begin
         if (diff) begin
            e   = d[0] ^ (m_k % 2);
            m_k = e;
         end else begin
            e   = d[0];
            m_k = e ? 0 : 2;
         end
         ei = e ? AB : -AB;
         eq = 0;
      end else begin
         if (diff) m_k = (m_k + gray_q[d]) % 4;
         else      m_k = gray_q[d];
         ei = sgn_i[m_k] * AQ;
         eq = sgn_q[m_k] * AQ;
      end
   endtask

   // Present one symbol, wait (bounded) for acceptance, push expectations
   task automatic send(input bit mode, input bit diff, input int cps,
                       input logic [1:0] d);
      int   ei, eq, p;
      bit   ok;
      exp_t x;
      bus.mode_i           = mode;
      bus.diff_en_i        = diff;
      bus.cycles_per_sym_i = CW'(cps);
      bus.data_i           = d;
      bus.valid_i          = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (bus.ready_o) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin
         check("accept_timeout", 0, 1);
         bus.valid_i = 1'b0;
         return;
      end
      model(mode, diff, d, ei, eq);
      p = (cps == 0) ? 1 : cps;
      x.i = IQW'(ei);
      x.q = IQW'(eq);
      x.v = 1'b1;
      x.u = 1'b0;
      for (int n = 0; n < p; n++) sb.push_back(x);
      @(posedge clk); #1;
      // Mid-symbol input scribble: must not affect the held symbol
      bus.mode_i           = ~mode;
      bus.cycles_per_sym_i = CW'($urandom_range(0, 5));
   endtask

   // Starve the modulator after the current symbol and expect one underrun
   task automatic gap(input int cps);
      exp_t x;
      int   p;
      p = (cps == 0) ? 1 : cps;
      bus.valid_i = 1'b0;
      x.i = '0; x.q = '0; x.v = 1'b0; x.u = 1'b1;
      sb.push_back(x);
      repeat (p + 2) @(posedge clk);
      #1;
   endtask

   // Monitor: compare each presented output cycle against the scoreboard
   always @(negedge clk) begin
      exp_t x;
      if (!rst && (bus.valid_o || bus.underrun_o)) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            x = sb.pop_front();
            check("i_data", int'(bus.i_data_o), int'(x.i));
            check("q_data", int'(bus.q_data_o), int'(x.q));
            check("valid",  int'(bus.valid_o),  int'(x.v));
            check("underrun", int'(bus.underrun_o), int'(x.u));
         end
      end
   end

   task automatic drain();
      for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 0);
   endtask

   initial begin
      bus.mode_i = 1'b0; bus.diff_en_i = 1'b0; bus.cycles_per_sym_i = '0;
      bus.data_i = 2'b00; bus.valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_i",     int'(bus.i_data_o), 0);
      check("rst_q",     int'(bus.q_data_o), 0);
      check("rst_valid", int'(bus.valid_o), 0);
      check("rst_und",   int'(bus.underrun_o), 0);
      check("rst_ready", int'(bus.ready_o), 1);
      rst = 1'b0;
      #1;

      // BPSK P=4 bits 1,0, then starve
      send(0, 0, 4, 2'b01);
      send(0, 0, 4, 2'b00);
      gap(4);
      drain();

      // QPSK non-differential P=2 over all dibits, back to back
      send(1, 0, 2, 2'b00);
      send(1, 0, 2, 2'b01);
      send(1, 0, 2, 2'b11);
      send(1, 0, 2, 2'b10);
      gap(2);
      drain();

      // Differential BPSK from reset
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0; m_k = 0;
      send(0, 1, 3, 2'b01);
      send(0, 1, 3, 2'b01);
      send(0, 1, 3, 2'b00);
      send(0, 1, 3, 2'b01);
      gap(3);
      drain();

      // Differential QPSK from reset
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0; m_k = 0;
      send(1, 1, 2, 2'b01);
      send(1, 1, 2, 2'b01);
      send(1, 1, 2, 2'b11);
      gap(2);
      drain();

      // Zero period: new symbol every clock, ready held high
      for (int n = 0; n < 8; n++) begin
         send(n[0], 1'b0, 0, 2'($urandom_range(0, 3)));
         check("p1_ready", int'(bus.ready_o), 1);
      end
      gap(0);
      drain();

      // Randomised traffic with occasional starvation
      for (int n = 0; n < 60; n++) begin
         int c;
         c = $urandom_range(0, 5);
         send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c,
              2'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) gap(c);
      end
      bus.valid_i = 1'b0;
      begin
         exp_t x;
         x.i = '0; x.q = '0; x.v = 1'b0; x.u = 1'b1;
         sb.push_back(x);
      end
      drain();

      // Reset on cycle 2 of a P=8 symbol
      send(1, 1, 8, 2'b01);
      bus.valid_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      m_k = 0;
      check("mrst_i",     int'(bus.i_data_o), 0);
      check("mrst_q",     int'(bus.q_data_o), 0);
      check("mrst_valid", int'(bus.valid_o), 0);
      check("mrst_und",   int'(bus.underrun_o), 0);
      check("mrst_ready", int'(bus.ready_o), 1);
      @(posedge clk); #1;
      check("mrst_und2",  int'(bus.underrun_o), 0);
      // Differential state must restart from zero
      send(1, 1, 1, 2'b01);
      gap(1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
